// File: rtl/demux2_4b_buf.sv
// Buffered 1-to-2 val/rdy demultiplexer: each input message is steered by in_sel
// into one of two independent 2-entry FIFOs, each draining on its own stream.

module demux2_4b_buf_queue #(
    parameter int p_nbits = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq,
    input  logic [p_nbits-1:0] enq_msg,
    input  logic               deq_rdy,
    output logic               deq_val,
    output logic [p_nbits-1:0] deq_msg,
    output logic               full
);

    logic [p_nbits-1:0] storage [2];
    logic               enq_ptr;
    logic               deq_ptr;
    logic [1:0]         count;
    logic               deq;

    assign deq_val = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign deq     = deq_val && deq_rdy;

    // Head is masked to zero while empty so stale storage never leaks out.
    assign deq_msg = deq_val ? storage[deq_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enq_ptr <= 1'b0;
            deq_ptr <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (enq) begin
                enq_ptr <= ~enq_ptr;
            end
            if (deq) begin
                deq_ptr <= ~deq_ptr;
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            storage[enq_ptr] <= enq_msg;
        end
    end

endmodule

// Valid/ready: a transfer happens on a rising edge where both val and rdy are 1;
// in_rdy looks only at in_sel and the registered fill level, never at out*_rdy.
module demux2_4b_buf #(
    parameter int p_nbits = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    input  logic               in_sel,
    output logic               out0_val,
    input  logic               out0_rdy,
    output logic [p_nbits-1:0] out0_msg,
    output logic               out1_val,
    input  logic               out1_rdy,
    output logic [p_nbits-1:0] out1_msg
);

    logic full0;
    logic full1;
    logic enq0;
    logic enq1;
    logic fire;

    assign in_rdy = in_sel ? !full1 : !full0;
    assign fire   = in_val && in_rdy;
    assign enq0   = fire && !in_sel;
    assign enq1   = fire && in_sel;

    demux2_4b_buf_queue #(.p_nbits(p_nbits)) u_q0 (
        .clk     (clk),
        .reset_n (reset_n),
        .enq     (enq0),
        .enq_msg (in_msg),
        .deq_rdy (out0_rdy),
        .deq_val (out0_val),
        .deq_msg (out0_msg),
        .full    (full0)
    );

    demux2_4b_buf_queue #(.p_nbits(p_nbits)) u_q1 (
        .clk     (clk),
        .reset_n (reset_n),
        .enq     (enq1),
        .enq_msg (in_msg),
        .deq_rdy (out1_rdy),
        .deq_val (out1_val),
        .deq_msg (out1_msg),
        .full    (full1)
    );

endmodule

// File: tb/tb_demux2_4b_buf.sv
// Directed self-checking bench for demux2_4b_buf with hand-computed expectations.

module tb_demux2_4b_buf;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_msg;
    logic       in_sel;
    logic       out0_val;
    logic       out0_rdy;
    logic [3:0] out0_msg;
    logic       out1_val;
    logic       out1_rdy;
    logic [3:0] out1_msg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux2_4b_buf #(.p_nbits(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_msg   (in_msg),
        .in_sel   (in_sel),
        .out0_val (out0_val),
        .out0_rdy (out0_rdy),
        .out0_msg (out0_msg),
        .out1_val (out1_val),
        .out1_rdy (out1_rdy),
        .out1_msg (out1_msg)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_val   = 1'b1;
        in_msg   = 4'hF;
        in_sel   = 1'b0;
        out0_rdy = 1'b0;
        out1_rdy = 1'b0;

        // reset held across edges with a valid input pending
        step();
        step();
        chk("rst_out0_val", {3'b0, out0_val}, 4'h0);
        chk("rst_out1_val", {3'b0, out1_val}, 4'h0);
        chk("rst_out0_msg", out0_msg, 4'h0);
        chk("rst_out1_msg", out1_msg, 4'h0);
        chk("rst_in_rdy", {3'b0, in_rdy}, 4'h1);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_out0_val", {3'b0, out0_val}, 4'h1);
        chk("post_rst_out0_msg", out0_msg, 4'hF);
        chk("post_rst_out1_val", {3'b0, out1_val}, 4'h0);
        in_val   = 1'b0;
        out0_rdy = 1'b1;
        out1_rdy = 1'b1;
        step();
        chk("drain_f_out0_val", {3'b0, out0_val}, 4'h0);

        // routing to both outputs
        in_val = 1'b1;
        in_msg = 4'b1010;
        in_sel = 1'b0;
        step();
        chk("route_out0_val", {3'b0, out0_val}, 4'h1);
        chk("route_out0_msg", out0_msg, 4'b1010);
        chk("route_out1_val_idle", {3'b0, out1_val}, 4'h0);
        in_msg = 4'b0101;
        in_sel = 1'b1;
        step();
        chk("route_out0_popped", {3'b0, out0_val}, 4'h0);
        chk("route_out1_val", {3'b0, out1_val}, 4'h1);
        chk("route_out1_msg", out1_msg, 4'b0101);
        in_val = 1'b0;
        step();
        chk("route_out1_popped", {3'b0, out1_val}, 4'h0);

        // fill queue0, check per-destination backpressure
        out0_rdy = 1'b0;
        out1_rdy = 1'b0;
        in_val   = 1'b1;
        in_sel   = 1'b0;
        in_msg   = 4'h1;
        step();
        in_msg = 4'h2;
        step();
        chk("full0_in_rdy_sel0", {3'b0, in_rdy}, 4'h0);
        in_sel = 1'b1;
        in_msg = 4'h3;
        #1;
        chk("full0_in_rdy_sel1", {3'b0, in_rdy}, 4'h1);
        step();
        chk("sel1_out1_msg", out1_msg, 4'h3);
        chk("full0_head", out0_msg, 4'h1);
        in_val   = 1'b0;
        in_sel   = 1'b0;
        out0_rdy = 1'b1;
        step();
        chk("drain_second", out0_msg, 4'h2);
        chk("in_rdy_reasserted", {3'b0, in_rdy}, 4'h1);
        step();
        chk("drain_empty", {3'b0, out0_val}, 4'h0);
        out1_rdy = 1'b1;
        step();
        chk("out1_drained", {3'b0, out1_val}, 4'h0);

        // simultaneous enqueue and dequeue on queue1
        out1_rdy = 1'b0;
        in_val   = 1'b1;
        in_sel   = 1'b1;
        in_msg   = 4'h7;
        step();
        chk("simul_head7", out1_msg, 4'h7);
        out1_rdy = 1'b1;
        in_msg   = 4'h8;
        #1;
        chk("simul_in_rdy", {3'b0, in_rdy}, 4'h1);
        step();
        chk("simul_out1_val", {3'b0, out1_val}, 4'h1);
        chk("simul_out1_msg", out1_msg, 4'h8);
        in_val = 1'b0;
        step();
        chk("simul_count1_drained", {3'b0, out1_val}, 4'h0);

        // full-rate stream through queue0 exercising pointer wrap
        in_val   = 1'b1;
        in_sel   = 1'b0;
        out0_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_msg = 4'(i);
            step();
            chk("stream_val", {3'b0, out0_val}, 4'h1);
            chk("stream_msg", out0_msg, 4'(i));
        end
        in_val = 1'b0;
        step();
        chk("stream_end_val", {3'b0, out0_val}, 4'h0);

        // full queue with a dequeue in the same cycle blocks the enqueue
        out0_rdy = 1'b0;
        in_val   = 1'b1;
        in_msg   = 4'hA;
        step();
        in_msg = 4'hB;
        step();
        in_msg   = 4'hC;
        out0_rdy = 1'b1;
        #1;
        chk("fulldeq_in_rdy", {3'b0, in_rdy}, 4'h0);
        step();
        chk("fulldeq_head_b", out0_msg, 4'hB);
        chk("fulldeq_in_rdy_next", {3'b0, in_rdy}, 4'h1);
        step();
        chk("fulldeq_head_c", out0_msg, 4'hC);
        in_val = 1'b0;
        step();
        chk("fulldeq_empty", {3'b0, out0_val}, 4'h0);

        // asynchronous reset between edges discards queued messages
        out0_rdy = 1'b0;
        out1_rdy = 1'b0;
        in_val   = 1'b1;
        in_sel   = 1'b0;
        in_msg   = 4'h5;
        step();
        in_sel = 1'b1;
        in_msg = 4'h6;
        step();
        in_val = 1'b0;
        chk("pre_mid_out0_msg", out0_msg, 4'h5);
        chk("pre_mid_out1_msg", out1_msg, 4'h6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out0_val", {3'b0, out0_val}, 4'h0);
        chk("mid_rst_out1_val", {3'b0, out1_val}, 4'h0);
        chk("mid_rst_out0_msg", out0_msg, 4'h0);
        chk("mid_rst_out1_msg", out1_msg, 4'h0);
        #1;
        reset_n  = 1'b1;
        out0_rdy = 1'b1;
        out1_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_out0_val", {3'b0, out0_val}, 4'h0);
            chk("after_rst_out1_val", {3'b0, out1_val}, 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
